segment_capture_ctrl: RTL and testbench

//  Consumer end of the trigger handshake: turns capture_go pulses into per-segment ADC sample

---
 rtl/segment_capture_if.sv | 30 +++
 rtl/segment_capture_ctrl.sv | 112 +++++++++++
 tb/tb_segment_capture_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/segment_capture_if.sv
// Bus between the trigger unit / sample FIFO side and the segment capture controller.
// The controller attaches through the slave modport, the driving side through master.
interface segment_capture_if #(
    parameter int SEG_W  = 16,
    parameter int SAMP_W = 32
);
    logic              arm_i;
    logic              capture_go_i;
    logic [SAMP_W-1:0] num_samples_i;
    logic [SEG_W-1:0]  num_segments_i;
    logic              fifo_full_i;
    logic              adc_write_en_o;
    logic [SEG_W-1:0]  segment_num_o;
    logic [SAMP_W-1:0] samples_total_o;
    logic              capture_done_o;
    logic              missed_go_o;
    logic              overflow_o;

    modport slave (
        input  arm_i, capture_go_i, num_samples_i, num_segments_i, fifo_full_i,
        output adc_write_en_o, segment_num_o, samples_total_o, capture_done_o,
               missed_go_o, overflow_o
    );

    modport master (
        output arm_i, capture_go_i, num_samples_i, num_segments_i, fifo_full_i,
        input  adc_write_en_o, segment_num_o, samples_total_o, capture_done_o,
               missed_go_o, overflow_o
    );
endinterface

// File: rtl/segment_capture_ctrl.sv
// Turns capture_go pulses into per-segment ADC write strobes, counting samples and
// segments, and reports capture_done back to the trigger logic (adc_clk domain).
module segment_capture_ctrl #(
    parameter int SEG_W  = 16,
    parameter int SAMP_W = 32
) (
    input  logic                  adc_clk,
    input  logic                  reset_n,
    segment_capture_if.slave      bus
);
    typedef enum logic [1:0] {IDLE, WAIT_GO, CAPTURE, DONE} state_e;

    state_e            state_q;
    logic              arm_dly_q;
    logic [SAMP_W-1:0] nsamp_q;
    logic [SEG_W-1:0]  nseg_q;
    logic [SAMP_W-1:0] samp_cnt_q;
    logic [SEG_W-1:0]  seg_q;
    logic [SAMP_W-1:0] total_q;
    logic              done_q;
    logic              missed_q;
    logic              ovf_q;

    logic              arm_rise_d;
    logic              last_samp_d;
    logic              last_seg_d;
    logic [SAMP_W-1:0] total_inc_d;

    assign arm_rise_d  = bus.arm_i & ~arm_dly_q;
    assign last_samp_d = (samp_cnt_q == nsamp_q - SAMP_W'(1));
    assign last_seg_d  = (seg_q == nseg_q - SEG_W'(1));
    assign total_inc_d = (total_q == '1) ? total_q : total_q + SAMP_W'(1);

    // Only the write strobe is combinational so a full FIFO blocks the write in the same cycle.
    assign bus.adc_write_en_o  = (state_q == CAPTURE) & ~bus.fifo_full_i;
    assign bus.segment_num_o   = seg_q;
    assign bus.samples_total_o = total_q;
    assign bus.capture_done_o  = done_q;
    assign bus.missed_go_o     = missed_q;
    assign bus.overflow_o      = ovf_q;

    always_ff @(posedge adc_clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            arm_dly_q  <= 1'b0;
            nsamp_q    <= '0;
            nseg_q     <= '0;
            samp_cnt_q <= '0;
            seg_q      <= '0;
            total_q    <= '0;
            done_q     <= 1'b0;
            missed_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            arm_dly_q <= bus.arm_i;
            case (state_q)
                IDLE: begin
                    if (arm_rise_d) begin
                        state_q  <= WAIT_GO;
                        nsamp_q  <= (bus.num_samples_i == '0) ? SAMP_W'(1) : bus.num_samples_i;
                        nseg_q   <= (bus.num_segments_i == '0) ? SEG_W'(1) : bus.num_segments_i;
                        seg_q    <= '0;
                        total_q  <= '0;
                        missed_q <= 1'b0;
                        ovf_q    <= 1'b0;
                    end
                end
                WAIT_GO: begin
                    if (!bus.arm_i) begin
                        state_q <= IDLE;
                    end else if (bus.capture_go_i) begin
                        state_q    <= CAPTURE;
                        samp_cnt_q <= '0;
                    end
                end
                CAPTURE: begin
                    if (!bus.arm_i) begin
                        // Abort: the strobe already went out this cycle, so it still counts.
                        state_q <= IDLE;
                        if (!bus.fifo_full_i) total_q <= total_inc_d;
                    end else if (bus.fifo_full_i) begin
                        ovf_q   <= 1'b1;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        samp_cnt_q <= samp_cnt_q + SAMP_W'(1);
                        total_q    <= total_inc_d;
                        if (last_samp_d) begin
                            if (last_seg_d) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                seg_q <= seg_q + SEG_W'(1);
                                if (bus.capture_go_i) samp_cnt_q <= '0;
                                else                  state_q    <= WAIT_GO;
                            end
                        end else if (bus.capture_go_i) begin
                            missed_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.arm_i) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_segment_capture_ctrl.sv
// Directed bench for segment_capture_ctrl: inputs change just after negedge, outputs
// are sampled mid-cycle; write strobes are counted and kept as a per-cycle history.
module tb_segment_capture_ctrl;
    localparam int SEG_W  = 16;
    localparam int SAMP_W = 32;

    logic adc_clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   wr_cnt  = 0;
    logic [31:0] wr_hist = '0;

    segment_capture_if #(.SEG_W(SEG_W), .SAMP_W(SAMP_W)) bus ();

    segment_capture_ctrl #(.SEG_W(SEG_W), .SAMP_W(SAMP_W)) dut (
        .adc_clk (adc_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record this cycle's strobe, then move to the next negedge.
    task automatic step();
        #1;
        wr_hist = {wr_hist[30:0], bus.adc_write_en_o};
        if (bus.adc_write_en_o === 1'b1) wr_cnt++;
        @(negedge adc_clk);
    endtask

    task automatic clr();
        wr_cnt  = 0;
        wr_hist = '0;
    endtask

    initial begin
        bus.arm_i = 0; bus.capture_go_i = 0; bus.fifo_full_i = 0;
        bus.num_samples_i = '0; bus.num_segments_i = '0;
        @(negedge adc_clk);
        step(); step();
        chk("rst_we",    32'(bus.adc_write_en_o), 0);
        chk("rst_done",  32'(bus.capture_done_o), 0);
        chk("rst_seg",   32'(bus.segment_num_o), 0);
        chk("rst_total", bus.samples_total_o, 0);
        chk("rst_miss",  32'(bus.missed_go_o), 0);
        chk("rst_ovf",   32'(bus.overflow_o), 0);
        reset_n = 1;

        // 1: single segment of 4
        bus.num_samples_i = 4; bus.num_segments_i = 1; bus.arm_i = 1;
        step(); clr();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step(); step(); step();
        chk("t1_hist",  wr_hist & 32'h1f, 32'h0f);
        chk("t1_done",  32'(bus.capture_done_o), 1);
        chk("t1_total", bus.samples_total_o, 4);
        step();
        chk("t1_wrcnt", 32'(wr_cnt), 4);
        bus.arm_i = 0; step();
        chk("t1_done_clr", 32'(bus.capture_done_o), 0);
        chk("t1_total_hold", bus.samples_total_o, 4);

        // 2: three segments of 3, config change after arm must be ignored
        bus.num_samples_i = 3; bus.num_segments_i = 3; bus.arm_i = 1;
        step(); clr();
        bus.num_samples_i = 7; bus.num_segments_i = 1;
        for (int s = 0; s < 3; s++) begin
            bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
            chk($sformatf("t2_seg%0d", s), 32'(bus.segment_num_o), 32'(s));
            for (int k = 0; k < 10; k++) step();
        end
        chk("t2_wrcnt", 32'(wr_cnt), 9);
        chk("t2_total", bus.samples_total_o, 9);
        chk("t2_seg_last", 32'(bus.segment_num_o), 2);
        chk("t2_done", 32'(bus.capture_done_o), 1);
        bus.arm_i = 0; step();

        // 3: back-to-back segments, go on last sample of seg0
        bus.num_samples_i = 2; bus.num_segments_i = 2; bus.arm_i = 1;
        step(); clr();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step(); step();
        chk("t3_hist",  wr_hist & 32'h3f, 32'h1e);
        chk("t3_wrcnt", 32'(wr_cnt), 4);
        chk("t3_miss",  32'(bus.missed_go_o), 0);
        chk("t3_done",  32'(bus.capture_done_o), 1);
        chk("t3_seg",   32'(bus.segment_num_o), 1);
        bus.arm_i = 0; step();

        // 4: stray go mid-segment
        bus.num_samples_i = 8; bus.num_segments_i = 1; bus.arm_i = 1;
        step(); clr();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step(); step();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        for (int k = 0; k < 6; k++) step();
        chk("t4_wrcnt", 32'(wr_cnt), 8);
        chk("t4_miss",  32'(bus.missed_go_o), 1);
        chk("t4_total", bus.samples_total_o, 8);
        chk("t4_done",  32'(bus.capture_done_o), 1);
        bus.arm_i = 0; step();
        chk("t4_miss_hold", 32'(bus.missed_go_o), 1);

        // 5: FIFO full on the 3rd sample aborts the capture
        bus.num_samples_i = 8; bus.num_segments_i = 1; bus.arm_i = 1;
        step(); clr();
        chk("t5_miss_clr",  32'(bus.missed_go_o), 0);
        chk("t5_total_clr", bus.samples_total_o, 0);
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step();
        bus.fifo_full_i = 1;
        #1 chk("t5_we_blocked", 32'(bus.adc_write_en_o), 0);
        step(); bus.fifo_full_i = 0;
        chk("t5_ovf",   32'(bus.overflow_o), 1);
        chk("t5_done",  32'(bus.capture_done_o), 1);
        chk("t5_total", bus.samples_total_o, 2);
        step();
        chk("t5_wrcnt", 32'(wr_cnt), 2);
        bus.arm_i = 0; step();
        chk("t5_done_clr", 32'(bus.capture_done_o), 0);
        chk("t5_ovf_hold", 32'(bus.overflow_o), 1);

        // 6: zero config means one sample, one segment; then abort mid-capture
        bus.num_samples_i = 0; bus.num_segments_i = 0; bus.arm_i = 1;
        step(); clr();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step();
        chk("t6_wrcnt", 32'(wr_cnt), 1);
        chk("t6_done",  32'(bus.capture_done_o), 1);
        chk("t6_total", bus.samples_total_o, 1);
        bus.arm_i = 0; step();
        bus.num_samples_i = 5; bus.num_segments_i = 1; bus.arm_i = 1;
        step(); clr();
        bus.capture_go_i = 1; step(); bus.capture_go_i = 0;
        step(); step();
        bus.arm_i = 0; step();
        for (int k = 0; k < 4; k++) begin
            bus.capture_go_i = (k == 1); step();
        end
        bus.capture_go_i = 0;
        chk("t6_abort_wrcnt", 32'(wr_cnt), 3);
        chk("t6_abort_done",  32'(bus.capture_done_o), 0);
        chk("t6_abort_we",    32'(bus.adc_write_en_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
